uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_transmitter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and parity helper.
// Used by the transmitter and intended for reuse by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Parity bit that makes data+parity ones-count even (PARITY_EVEN) or odd (PARITY_ODD).
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clocks within one bit and flags the last cycle of the period.
// clear restarts the period; the counter also wraps on its own at the end of each period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_CLOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (BAUD_CLOCK_CYCLES > 1) ? $clog2(BAUD_CLOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_CLOCK_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// All outputs are registered; next values are derived from the next FSM state.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE     = 19_200,
    parameter int unsigned NUM_DATA_BITS = 8,
    parameter int unsigned PARITY_EN     = 1,
    parameter int unsigned NUM_STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_DATA_BITS-1:0] din,
    input  logic                     send,
    input  logic                     parity_mode,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int unsigned IDX_W             = $clog2(NUM_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA    = IDX_W'(NUM_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP    = IDX_W'(NUM_STOP_BITS - 1);

    uart_state_e              state, state_next;
    logic [IDX_W-1:0]         bit_idx, bit_idx_next;
    logic [NUM_DATA_BITS-1:0] data_q, data_next;
    logic                     mode_q, mode_next;
    logic                     tx_next, busy_next, done_next;
    logic [NUM_DATA_BITS-1:0] data_shift_c;
    logic                     baud_clear_c;
    logic                     tick;

    // Restart the bit period on every state or bit-index change, and hold it while idle.
    assign baud_clear_c = (state == IDLE) || (state_next != state) || (bit_idx_next != bit_idx);

    uart_baud_gen #(
        .BAUD_CLOCK_CYCLES(BAUD_CLOCK_CYCLES)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear_c),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            data_q  <= '0;
            mode_q  <= PARITY_EVEN;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            data_q  <= data_next;
            mode_q  <= mode_next;
            tx_out  <= tx_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        data_next    = data_q;
        mode_next    = mode_q;
        done_next    = 1'b0;
        tx_next      = 1'b1;

        case (state)
            IDLE: begin
                if (send) begin
                    state_next   = START;
                    bit_idx_next = '0;
                    data_next    = din;
                    mode_next    = parity_mode;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_DATA) begin
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next   = STOP;
                    bit_idx_next = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        state_next   = IDLE;
                        bit_idx_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                bit_idx_next = '0;
            end
        endcase

        busy_next    = (state_next != IDLE);
        data_shift_c = data_next >> bit_idx_next;

        // Line level for the cycle that follows this edge.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_shift_c[0];
            PARITY:  tx_next = parity_bit(MAX_DATA_BITS'(data_next), mode_next);
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two configurations (8E/O1 with parity, 7N2) at 10 clocks/bit.
// Stimulus pushes expected line frames; a negedge monitor checks every clock of each frame.
module tb_uart_transmitter;

    localparam int BIT = 10;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0;
    logic [6:0] din1;
    logic       send0, send1, pm0, pm1;
    logic       tx0, busy0, done0, tx1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;

    frame_t q0[$];
    frame_t q1[$];
    frame_t cur[2];
    int     cyc[2], bad[2], dcount[2], gap[2], b2b[2], exp_done[2];
    bit     in_frame[2], ended[2];

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
        .NUM_DATA_BITS(8), .PARITY_EN(1), .NUM_STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .din(din0), .send(send0), .parity_mode(pm0),
        .tx_out(tx0), .busy(busy0), .done(done0)
    );

    uart_transmitter #(
        .CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
        .NUM_DATA_BITS(7), .PARITY_EN(0), .NUM_STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din1), .send(send1), .parity_mode(pm1),
        .tx_out(tx1), .busy(busy1), .done(done1)
    );

    task automatic check(input int ch, input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL ch%0d %s: got %0d, expected %0d", ch, name, got, exp);
        end
    endtask

    // Monitor: frames begin at the first low line sample while idle.
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            logic        t, b, d, eb;
            logic [15:0] sh;
            int          total;
            t = (ch == 0) ? tx0 : tx1;
            b = (ch == 0) ? busy0 : busy1;
            d = (ch == 0) ? done0 : done1;
            if (rst) begin
                in_frame[ch] = 1'b0;
                ended[ch]    = 1'b0;
            end else begin
                if (d) dcount[ch]++;
                if (!in_frame[ch]) begin
                    if (t == 1'b0) begin
                        if (ended[ch] && gap[ch] == 0) b2b[ch]++;
                        ended[ch] = 1'b0;
                        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL ch%0d unexpected frame start: got line 0 with no pending frame, expected idle 1", ch);
                            cur[ch] = '{bits: 16'hFFFF, nbits: 11};
                        end else if (ch == 0) begin
                            cur[ch] = q0.pop_front();
                        end else begin
                            cur[ch] = q1.pop_front();
                        end
                        in_frame[ch] = 1'b1;
                        cyc[ch]      = 0;
                        bad[ch]      = 0;
                    end else if (ended[ch]) begin
                        gap[ch]++;
                    end
                end
                if (in_frame[ch]) begin
                    total = cur[ch].nbits * BIT;
                    if (cyc[ch] < total) begin
                        sh = cur[ch].bits >> (cyc[ch] / BIT);
                        eb = sh[0];
                        if (t !== eb || b !== 1'b1 || d !== 1'b0) bad[ch]++;
                        if (cyc[ch] % BIT == BIT - 1) begin
                            check(ch, $sformatf("line bit %0d (level %b) bad clocks", cyc[ch] / BIT, eb),
                                  bad[ch], 0);
                            bad[ch] = 0;
                        end
                    end else begin
                        check(ch, "frame end {tx,busy,done}", int'({t, b, d}), 5);
                        in_frame[ch] = 1'b0;
                        ended[ch]    = 1'b1;
                        gap[ch]      = 0;
                    end
                    cyc[ch]++;
                end
            end
        end
    end

    // Issue one frame; parity argument is the hand-computed line parity bit (ch0 only).
    task automatic send_frame(input int ch, input logic [7:0] d, input logic pm, input logic par);
        frame_t f;
        @(negedge clk);
        if (ch == 0) begin
            f.bits  = 16'({1'b1, par, d, 1'b0});
            f.nbits = 11;
            q0.push_back(f);
            din0  = d;
            pm0   = pm;
            send0 = 1'b1;
        end else begin
            f.bits  = 16'({2'b11, d[6:0], 1'b0});
            f.nbits = 10;
            q1.push_back(f);
            din1  = d[6:0];
            pm1   = pm;
            send1 = 1'b1;
        end
        exp_done[ch]++;
        @(posedge clk);
        #1;
        if (ch == 0) check(0, "accept {tx,busy}", int'({tx0, busy0}), 1);
        else         check(1, "accept {tx,busy}", int'({tx1, busy1}), 1);
        @(negedge clk);
        send0 = 1'b0;
        send1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || in_frame[0] || in_frame[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(0, "frame completes within budget", int'(n < 2000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        frame_t f;
        int     base, d0, n;
        rst = 1'b1;
        send0 = 1'b0; send1 = 1'b0;
        pm0 = 1'b0;   pm1 = 1'b0;
        din0 = '0;    din1 = '0;
        for (int i = 0; i < 2; i++) begin
            dcount[i] = 0; gap[i] = 0; b2b[i] = 0; exp_done[i] = 0;
            in_frame[i] = 1'b0; ended[i] = 1'b0; cyc[i] = 0; bad[i] = 0;
        end
        repeat (3) @(negedge clk);
        check(0, "reset {tx,busy,done}", int'({tx0, busy0, done0}), 4);
        check(1, "reset {tx,busy,done}", int'({tx1, busy1, done1}), 4);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Parity frames on the 8-bit channel
        send_frame(0, 8'hA5, 1'b0, 1'b0); wait_idle();
        send_frame(0, 8'h00, 1'b1, 1'b1); wait_idle();
        send_frame(0, 8'hFF, 1'b0, 1'b0); wait_idle();
        send_frame(0, 8'h5A, 1'b1, 1'b1); wait_idle();

        // 7N2 channel
        send_frame(1, 8'h41, 1'b0, 1'b0); wait_idle();
        send_frame(1, 8'h2A, 1'b1, 1'b0); wait_idle();

        // send and new data mid-frame are ignored
        send_frame(0, 8'hC3, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        din0  = 8'h3C;
        pm0   = 1'b1;
        send0 = 1'b1;
        @(posedge clk);
        #1;
        check(0, "busy during ignored send", int'(busy0), 1);
        @(negedge clk);
        send0 = 1'b0;
        wait_idle();

        // send held high: three back-to-back frames
        base = b2b[0];
        d0   = dcount[0];
        f.bits  = 16'({1'b1, 1'b0, 8'h81, 1'b0});
        f.nbits = 11;
        repeat (3) q0.push_back(f);
        exp_done[0] += 3;
        @(negedge clk);
        din0  = 8'h81;
        pm0   = 1'b0;
        send0 = 1'b1;
        n = 0;
        while (dcount[0] < d0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(0, "second held-send done within budget", int'(n < 500), 1);
        @(posedge clk);
        @(negedge clk);
        send0 = 1'b0;
        wait_idle();
        check(0, "frames with one idle cycle gap", b2b[0] - base, 2);

        // reset during data bit 4, then a clean frame
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        repeat (54) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(0, "async reset {tx,busy,done}", int'({tx0, busy0, done0}), 4);
        q0.delete();
        exp_done[0]--;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check(0, "idle line after reset", int'({tx0, busy0}), 2);
        send_frame(0, 8'hA5, 1'b1, 1'b1);
        wait_idle();

        check(0, "done pulse count", dcount[0], exp_done[0]);
        check(1, "done pulse count", dcount[1], exp_done[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
